// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - frame request and serial line status bundle for piso_tx
interface piso_tx_if #(
    parameter int FRAME_WIDTH = 11
);
    logic                   send;
    logic [FRAME_WIDTH-1:0] data_parll;
    logic                   data_tx;
    logic                   active_flag;
    logic                   done_flag;

    modport master (
        output send,
        output data_parll,
        input  data_tx,
        input  active_flag,
        input  done_flag
    );

    modport slave (
        input  send,
        input  data_parll,
        output data_tx,
        output active_flag,
        output done_flag
    );
endinterface

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - UART frame serializer, LSB-first, TICKS_PER_BIT baud ticks per bit
module piso_tx #(
    parameter int FRAME_WIDTH   = 11,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       baud_clk,
    input  logic       reset,
    piso_tx_if.slave   bus
);
    localparam int TW = $clog2(TICKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t                 state;
    logic [FRAME_WIDTH-1:0] shift_reg;
    logic [3:0]             bit_count;
    logic [TW-1:0]          tick_count;
    logic                   data_tx;
    logic                   active_flag;
    logic                   done_flag;

    assign bus.data_tx     = data_tx;
    assign bus.active_flag = active_flag;
    assign bus.done_flag   = done_flag;

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '1;
            bit_count   <= '0;
            tick_count  <= '0;
            data_tx     <= 1'b1;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_tx     <= 1'b1;
                    active_flag <= 1'b0;
                    done_flag   <= 1'b0;
                    if (bus.send) begin
                        shift_reg   <= bus.data_parll;
                        data_tx     <= bus.data_parll[0];
                        active_flag <= 1'b1;
                        bit_count   <= '0;
                        tick_count  <= '0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    tick_count <= tick_count + TW'(1);
                    if (tick_count == TW'(TICKS_PER_BIT - 1) &&
                        bit_count < 4'(FRAME_WIDTH - 1)) begin
                        shift_reg  <= {1'b1, shift_reg[FRAME_WIDTH-1:1]};
                        data_tx    <= shift_reg[1];
                        bit_count  <= bit_count + 4'd1;
                        tick_count <= '0;
                    end else if (tick_count == TW'(TICKS_PER_BIT - 2) &&
                                 bit_count == 4'(FRAME_WIDTH - 1)) begin
                        // Enter DONE on the last tick of the stop bit so the
                        // registered DONE outputs land exactly when its hold ends.
                        state <= DONE;
                    end
                end
                DONE: begin
                    data_tx     <= 1'b1;
                    active_flag <= 1'b0;
                    done_flag   <= 1'b1;
                    tick_count  <= '0;
                    state       <= IDLE;
                end
                default: begin
                    data_tx     <= 1'b1;
                    active_flag <= 1'b0;
                    done_flag   <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
